unified_mem_arbiter: RTL and testbench

Sequences a single-port unified memory shared by three requesters of the multi-cycle CPU: instruction fetch, data load/store and the debug loader. It sits between the control unit's fetch/memory-stage strobes and the memory macro. It grants one transaction at a time using round-robin priority. It converts each grant into a registered memory command and waits for a variable-latency ready. It returns a one-cycle ack, with an error flag on timeout.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_rr3.sv | 25 ++
 rtl/unified_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] REQ_IF   = 2'd0;
    localparam logic [1:0] REQ_D    = 2'd1;
    localparam logic [1:0] REQ_DBG  = 2'd2;
    localparam logic [1:0] REQ_NONE = 2'd3;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Successor in the 3-entry ring IF -> D -> DBG -> IF.
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id >= REQ_DBG) ? REQ_IF : id + 2'd1;
    endfunction

endpackage

// File: rtl/mem_arb_rr3.sv
// Combinational 3-way round-robin pick: searches last+1, last+2, last.
module mem_arb_rr3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] win_id,
    output logic       win_vld
);

    always_comb begin
        logic [1:0] cand;
        win_id  = REQ_NONE;
        win_vld = 1'b0;
        cand    = last;
        for (int i = 0; i < 3; i++) begin
            cand = rr_next(cand);
            if (!win_vld && req[cand]) begin
                win_id  = cand;
                win_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory sequencer for fetch, data and debug requesters:
// round-robin grant, registered command, ready wait with timeout, one-cycle ack.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 15
)(
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    grant_id,
    output logic          busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [1:0]    last_q;
    logic [1:0]    win_id;
    logic          win_vld;
    logic [CW-1:0] cnt;
    logic          tmo;
    logic          done;
    logic [DW-1:0] rd_val;

    mem_arb_rr3 u_rr (
        .req     ({dbg_req, d_req, if_req}),
        .last    (last_q),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    // Timeout fires on the WAIT cycle whose increment brings the counter to TIMEOUT.
    assign tmo    = !mem_ready && (cnt == CW'(TIMEOUT - 1));
    assign rd_val = mem_ready ? mem_rdata : '0;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (win_vld) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_ready || tmo) begin
                    state_nxt = S_RESP;
                    done      = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_id  <= REQ_NONE;
            last_q    <= REQ_IF;
            cnt       <= '0;
            err       <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            dbg_ack   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            dbg_rdata <= '0;
        end else begin
            mem_en  <= 1'b0;
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        mem_en   <= 1'b1;
                        grant_id <= win_id;
                        last_q   <= win_id;
                        case (win_id)
                            REQ_D: begin
                                mem_we    <= d_we;
                                mem_addr  <= d_addr;
                                mem_wdata <= d_wdata;
                            end
                            REQ_DBG: begin
                                mem_we    <= dbg_we;
                                mem_addr  <= dbg_addr;
                                mem_wdata <= dbg_wdata;
                            end
                            default: begin
                                // fetch is read-only whatever the data port drives
                                mem_we    <= 1'b0;
                                mem_addr  <= if_addr;
                                mem_wdata <= '0;
                            end
                        endcase
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (!mem_ready) cnt <= cnt + CW'(1);
                    if (done) begin
                        err <= tmo;
                        case (grant_id)
                            REQ_D:   d_ack   <= 1'b1;
                            REQ_DBG: dbg_ack <= 1'b1;
                            default: if_ack  <= 1'b1;
                        endcase
                        if (!mem_we) begin
                            case (grant_id)
                                REQ_D:   d_rdata   <= rd_val;
                                REQ_DBG: dbg_rdata <= rd_val;
                                default: if_rdata  <= rd_val;
                            endcase
                        end
                    end
                end
                S_RESP: begin
                    err      <= 1'b0;
                    grant_id <= REQ_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized scoreboard bench for unified_mem_arbiter with a transaction-level reference model.
module tb_unified_mem_arbiter;

    logic        CLK, RST;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        err, mem_en, mem_we, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant_id;

    unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic [1:0]  id;
        logic        err;
        logic [31:0] rd0, rd1, rd2;
        int          lat;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   lat_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ptr;
    logic [31:0] ref_rd[3];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] env_mem[logic [31:0]];
    logic [31:0] p_addr[3], p_wdata[3];
    logic        p_we[3];
    int          p_lat[3];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
    endfunction

    // Memory macro: ready arrives lat+1 cycles after the mem_en cycle (lat 0 = next cycle).
    initial begin
        int          cnt;
        bit          pend;
        logic [31:0] pdata;
        mem_ready = 1'b0;
        mem_rdata = '0;
        pend = 0;
        cnt = 0;
        pdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = pdata;
                    pend = 0;
                end
            end
            if (mem_en) begin
                cnt = (lat_q.size() != 0) ? lat_q.pop_front() + 1 : 1;
                pend = 1;
                if (mem_we) begin
                    env_mem[mem_addr] = mem_wdata;
                    pdata = $urandom;
                end else begin
                    pdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : def_word(mem_addr);
                end
            end
        end
    end

    // Monitor: pops expected command on mem_en and expected response on any ack.
    initial begin
        bit         outstanding;
        int         en_cyc;
        cmd_t       mc;
        rsp_t       mr;
        logic [1:0] ack_id;
        outstanding = 0;
        en_cyc = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                outstanding = 0;
            end else begin
                if (mem_en) begin
                    chk("mem_en_overlap", 32'(outstanding), 0);
                    if (cmd_q.size() == 0) begin
                        chk("unexpected_mem_en", 1, 0);
                    end else begin
                        mc = cmd_q.pop_front();
                        chk("cmd_grant_id", 32'(grant_id), 32'(mc.id));
                        chk("cmd_we", 32'(mem_we), 32'(mc.we));
                        chk("cmd_addr", mem_addr, mc.addr);
                        if (mc.we) chk("cmd_wdata", mem_wdata, mc.wdata);
                        chk("cmd_busy", 32'(busy), 1);
                    end
                    outstanding = 1;
                    en_cyc = cyc;
                end
                if (if_ack || d_ack || dbg_ack) begin
                    chk("ack_onehot", 32'(int'(if_ack) + int'(d_ack) + int'(dbg_ack)), 1);
                    ack_id = if_ack ? 2'd0 : (d_ack ? 2'd1 : 2'd2);
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_ack", 1, 0);
                    end else begin
                        mr = rsp_q.pop_front();
                        chk("ack_port", 32'(ack_id), 32'(mr.id));
                        chk("ack_grant_id", 32'(grant_id), 32'(mr.id));
                        chk("ack_err", 32'(err), 32'(mr.err));
                        chk("if_rdata", if_rdata, mr.rd0);
                        chk("d_rdata", d_rdata, mr.rd1);
                        chk("dbg_rdata", dbg_rdata, mr.rd2);
                        chk("ack_latency", 32'(cyc - en_cyc), 32'(mr.lat));
                    end
                    outstanding = 0;
                end else if (err) begin
                    chk("err_without_ack", 32'(err), 0);
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
        chk({tag, "_acks"}, {29'd0, if_ack, d_ack, dbg_ack}, 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 3);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic randomize_payload(input bit allow_tmo);
        for (int i = 0; i < 3; i++) begin
            p_addr[i]  = 32'($urandom_range(0, 15)) << 2;
            p_wdata[i] = $urandom;
            p_we[i]    = 1'($urandom_range(0, 1));
            if (allow_tmo && $urandom_range(0, 7) == 0) p_lat[i] = 15 + $urandom_range(0, 1);
            else                                        p_lat[i] = $urandom_range(0, 14);
        end
    endtask

    // Predict grant order and responses, then play the requesters until every ack.
    task automatic run_batch(input logic [2:0] mask);
        logic [2:0] rem, pend;
        int         id, budget;
        bit         timed, we;
        cmd_t       c;
        rsp_t       r;
        rem = mask;
        while (rem != 0) begin
            id = -1;
            for (int i = 1; i <= 3; i++)
                if (id < 0 && rem[(ptr + i) % 3]) id = (ptr + i) % 3;
            ptr = id;
            rem[id] = 1'b0;
            we = (id != 0) && p_we[id];
            timed = (p_lat[id] > 14);
            c.id = 2'(id); c.we = we; c.addr = p_addr[id]; c.wdata = p_wdata[id];
            cmd_q.push_back(c);
            lat_q.push_back(p_lat[id]);
            if (we) ref_mem[p_addr[id]] = p_wdata[id];
            else    ref_rd[id] = timed ? 32'd0 : ref_read(p_addr[id]);
            r.id = 2'(id); r.err = timed;
            r.rd0 = ref_rd[0]; r.rd1 = ref_rd[1]; r.rd2 = ref_rd[2];
            r.lat = timed ? 16 : p_lat[id] + 2;
            rsp_q.push_back(r);
        end
        if_addr   = p_addr[0];
        d_we      = p_we[1];
        d_addr    = p_addr[1];
        d_wdata   = p_wdata[1];
        dbg_we    = p_we[2];
        dbg_addr  = p_addr[2];
        dbg_wdata = p_wdata[2];
        if_req    = mask[0];
        d_req     = mask[1];
        dbg_req   = mask[2];
        pend = mask;
        budget = 0;
        while (pend != 0 && budget < 120) begin
            @(negedge CLK);
            budget++;
            if (if_ack)  begin if_req  = 1'b0; pend[0] = 1'b0; end
            if (d_ack)   begin d_req   = 1'b0; pend[1] = 1'b0; end
            if (dbg_ack) begin dbg_req = 1'b0; pend[2] = 1'b0; end
        end
        chk("batch_all_acked", 32'(pend), 0);
        if_req = 1'b0; d_req = 1'b0; dbg_req = 1'b0;
    endtask

    initial begin
        int k;
        RST = 1'b1;
        if_req = 0; d_req = 0; dbg_req = 0;
        if_addr = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        ptr = 0;
        for (int i = 0; i < 3; i++) ref_rd[i] = '0;

        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset("por");
        RST = 1'b1;

        // all three at reset exit: data, debug, fetch
        randomize_payload(0);
        run_batch(3'b111);

        // single fetch of a known word, ready two cycles after mem_en
        randomize_payload(0);
        p_addr[0] = 32'h40;
        p_lat[0]  = 1;
        ref_mem[32'h40] = 32'h2011_0003;
        env_mem[32'h40] = 32'h2011_0003;
        run_batch(3'b001);

        // store then load back through the data port
        randomize_payload(0);
        p_we[1] = 1'b1; p_addr[1] = 32'h8; p_wdata[1] = 32'hDEAD_BEEF;
        run_batch(3'b010);
        randomize_payload(0);
        p_we[1] = 1'b0; p_addr[1] = 32'h8;
        run_batch(3'b010);

        // timeouts with a late ready landing in RESP, then in IDLE
        randomize_payload(0);
        p_lat[0] = 15;
        run_batch(3'b001);
        randomize_payload(0);
        p_we[1] = 1'b0; p_lat[1] = 16;
        run_batch(3'b010);

        // fetch while the data port drives a write enable
        randomize_payload(0);
        p_we[1] = 1'b1;
        run_batch(3'b001);

        repeat (60) begin
            randomize_payload(1);
            run_batch(3'($urandom_range(1, 7)));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        // reset while a data read sits in WAIT
        randomize_payload(0);
        begin
            cmd_t c;
            c.id = 2'd1; c.we = 1'b0; c.addr = p_addr[1]; c.wdata = p_wdata[1];
            cmd_q.push_back(c);
        end
        lat_q.push_back(10);
        d_we = 1'b0; d_addr = p_addr[1]; d_wdata = p_wdata[1]; d_req = 1'b1;
        k = 0;
        while (!mem_en && k < 10) begin
            @(negedge CLK);
            k++;
        end
        chk("abort_mem_en", 32'(mem_en), 1);
        repeat (3) @(negedge CLK);
        chk("abort_busy_in_wait", 32'(busy), 1);
        RST = 1'b0;
        d_req = 1'b0;
        ptr = 0;
        for (int i = 0; i < 3; i++) ref_rd[i] = '0;
        cmd_q.delete();
        rsp_q.delete();
        lat_q.delete();
        @(negedge CLK);
        check_reset("mid");
        RST = 1'b1;
        repeat (15) @(negedge CLK);
        chk("post_abort_idle", 32'(busy), 0);

        // fetch/data tie after reset: data wins
        randomize_payload(0);
        run_batch(3'b011);

        repeat (3) @(negedge CLK);
        chk("cmd_q_drained", 32'(cmd_q.size()), 0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
